alu_exec_unit: RTL

//  Execute-stage controller that sits on the driving side of the combinational Alu.
//  - Accepts one decoded command per valid/ready handshake.
//  - Reads operands from an internal 8x16 register file and drives the Alu inputs.
//  - Captures result and carry/zero/negative, writes the destination register and status flags.
//  - Serialised four-state FSM; one command in flight at a time.

---
 rtl/alu_exec_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage controller driving a combinational Alu: fetches operands from an
// internal register file, captures the Alu outputs and writes back result and flags.
module alu_exec_unit #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [2:0]        cmdOpType,
    input  logic [2:0]        cmdOp,
    input  logic [REG_AW-1:0] cmdDst,
    input  logic [REG_AW-1:0] cmdSrcA,
    input  logic [REG_AW-1:0] cmdSrcB,
    input  logic              cmdUseImm,
    input  logic [DATA_W-1:0] cmdImm,
    input  logic              cmdSetFlags,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic              carryIn,
    output logic [2:0]        operationType,
    output logic [2:0]        operation,
    input  logic [DATA_W-1:0] result,
    input  logic              carryOut,
    input  logic              zeroOut,
    input  logic              negativeOut,
    output logic              doneValid,
    output logic              flagC,
    output logic              flagZ,
    output logic              flagN,
    input  logic [REG_AW-1:0] dbgAddr,
    output logic [DATA_W-1:0] dbgData
);

    localparam int unsigned NREGS = 2 ** REG_AW;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state;
    logic [DATA_W-1:0] regFile [NREGS];

    logic [2:0]        latOpType;
    logic [2:0]        latOp;
    logic [REG_AW-1:0] latDst;
    logic [REG_AW-1:0] latSrcA;
    logic [REG_AW-1:0] latSrcB;
    logic              latUseImm;
    logic [DATA_W-1:0] latImm;
    logic              latSetFlags;

    logic [DATA_W-1:0] resVal;
    logic              resC;
    logic              resZ;
    logic              resN;

    assign cmdReady = (state == IDLE);
    assign carryIn  = flagC;
    assign dbgData  = regFile[dbgAddr];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            for (int unsigned i = 0; i < NREGS; i++) regFile[i] <= '0;
            latOpType     <= '0;
            latOp         <= '0;
            latDst        <= '0;
            latSrcA       <= '0;
            latSrcB       <= '0;
            latUseImm     <= 1'b0;
            latImm        <= '0;
            latSetFlags   <= 1'b0;
            operand1      <= '0;
            operand2      <= '0;
            operationType <= '0;
            operation     <= '0;
            resVal        <= '0;
            resC          <= 1'b0;
            resZ          <= 1'b0;
            resN          <= 1'b0;
            flagC         <= 1'b0;
            flagZ         <= 1'b0;
            flagN         <= 1'b0;
            doneValid     <= 1'b0;
        end else begin
            doneValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmdValid) begin
                        latOpType   <= cmdOpType;
                        latOp       <= cmdOp;
                        latDst      <= cmdDst;
                        latSrcA     <= cmdSrcA;
                        latSrcB     <= cmdSrcB;
                        latUseImm   <= cmdUseImm;
                        latImm      <= cmdImm;
                        latSetFlags <= cmdSetFlags;
                        state       <= READ;
                    end
                end
                READ: begin
                    // Register file is read after the previous writeback, so no forwarding path
                    operand1      <= regFile[latSrcA];
                    operand2      <= latUseImm ? latImm : regFile[latSrcB];
                    operationType <= latOpType;
                    operation     <= latOp;
                    state         <= EXEC;
                end
                EXEC: begin
                    resVal <= result;
                    resC   <= carryOut;
                    resZ   <= zeroOut;
                    resN   <= negativeOut;
                    state  <= WB;
                end
                WB: begin
                    regFile[latDst] <= resVal;
                    if (latSetFlags) begin
                        flagC <= resC;
                        flagZ <= resZ;
                        flagN <= resN;
                    end
                    doneValid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
